// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB-interface LCD timing generator with built-in test patterns.
//
// Raster timing:
// - Free-running h_cnt/v_cnt raster counters.
// - Each axis is ordered as active, front porch, sync, back porch.
//
// Output registering:
// - Every output is registered from the same (h_cnt, v_cnt) pair.
// - All outputs are therefore mutually aligned, one clk after the counters.
//
// Pattern select:
// - mode/solid_rgb are sampled only at pixel (0,0).
// - A mid-frame change takes effect at the next frame's first pixel.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   mode         pattern select (0 crossbar, 1 bars, 2 gray, 3 checker, 4 solid, 5-7 black)
//   solid_rgb    solid colour {r,g,b} for mode 4
//   lcd_hs/vs    sync outputs, active level HS_POL/VS_POL
//   lcd_de       data enable
//   lcd_r/g/b    pixel colour, zero outside the active area
//   active_x/y   coordinates of the current output pixel, zero outside the active area
//   frame_start  one-clk pulse with pixel (0,0)
//   frame_cnt    completed-frame counter
module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned H_FP      = 8,
  parameter int unsigned H_SYNC    = 1,
  parameter int unsigned H_BP      = 43,
  parameter int unsigned V_ACTIVE  = 272,
  parameter int unsigned V_FP      = 8,
  parameter int unsigned V_SYNC    = 1,
  parameter int unsigned V_BP      = 12,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned R_W       = 5,
  parameter int unsigned G_W       = 6,
  parameter int unsigned B_W       = 5,
  parameter int unsigned CB_SHIFT  = 4,
  parameter int unsigned CHK_SHIFT = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               mode,
  input  logic [R_W+G_W+B_W-1:0]   solid_rgb,
  output logic                     lcd_hs,
  output logic                     lcd_vs,
  output logic                     lcd_de,
  output logic [R_W-1:0]           lcd_r,
  output logic [G_W-1:0]           lcd_g,
  output logic [B_W-1:0]           lcd_b,
  output logic [11:0]              active_x,
  output logic [11:0]              active_y,
  output logic                     frame_start,
  output logic [7:0]               frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned RGB_W   = R_W + G_W + B_W;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic [2:0]       mode_q;
  logic [RGB_W-1:0] solid_q;
  logic             seen_first_q;

  logic             at_origin_c;
  logic             de_c;
  logic             hs_c;
  logic             vs_c;
  logic [2:0]       mode_eff_c;
  logic [RGB_W-1:0] solid_eff_c;
  logic [2:0]       bar_idx_c;
  logic [7:0]       x8_c;
  logic [R_W-1:0]   r_c;
  logic [G_W-1:0]   g_c;
  logic [B_W-1:0]   b_c;

  // Raster counters: h wraps every line, v advances on h wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Raster decode for the current counter position.
  always_comb begin
    at_origin_c = (h_cnt == '0) && (v_cnt == '0);
    de_c        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c        = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    vs_c        = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Pixel (0,0) must already use the value being latched on this edge.
  always_comb begin
    mode_eff_c  = at_origin_c ? mode      : mode_q;
    solid_eff_c = at_origin_c ? solid_rgb : solid_q;
  end

  // Colour-bar index from seven threshold comparators.
  always_comb begin
    bar_idx_c = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_cnt >= HW'(k * BAR_W)) begin
        bar_idx_c = bar_idx_c + 3'd1;
      end
    end
  end

  // Low byte of x for the gray ramp, so the ramp repeats every 256 pixels.
  always_comb begin
    x8_c = 8'(h_cnt);
  end

  // Pattern generator; everything outside the active area is black.
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (de_c) begin
      case (mode_eff_c)
        3'd0: begin
          r_c[R_W-1 -: 2] = h_cnt[CB_SHIFT +: 2];
          g_c[G_W-1 -: 2] = v_cnt[CB_SHIFT +: 2];
        end
        3'd1: begin
          // Bar order white..black maps onto inverted index bits.
          r_c = {R_W{~bar_idx_c[1]}};
          g_c = {G_W{~bar_idx_c[2]}};
          b_c = {B_W{~bar_idx_c[0]}};
        end
        3'd2: begin
          r_c = x8_c[7 -: R_W];
          g_c = x8_c[7 -: G_W];
          b_c = x8_c[7 -: B_W];
        end
        3'd3: begin
          if (h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]) begin
            r_c = '1;
            g_c = '1;
            b_c = '1;
          end
        end
        3'd4: begin
          {r_c, g_c, b_c} = solid_eff_c;
        end
        default: begin
          r_c = '0;
          g_c = '0;
          b_c = '0;
        end
      endcase
    end
  end

  // Output register plus the per-frame latches and frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcd_hs       <= ~HS_POL;
      lcd_vs       <= ~VS_POL;
      lcd_de       <= 1'b0;
      lcd_r        <= '0;
      lcd_g        <= '0;
      lcd_b        <= '0;
      active_x     <= '0;
      active_y     <= '0;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
      mode_q       <= '0;
      solid_q      <= '0;
      seen_first_q <= 1'b0;
    end else begin
      lcd_hs      <= hs_c;
      lcd_vs      <= vs_c;
      lcd_de      <= de_c;
      lcd_r       <= r_c;
      lcd_g       <= g_c;
      lcd_b       <= b_c;
      active_x    <= de_c ? 12'(h_cnt) : '0;
      active_y    <= de_c ? 12'(v_cnt) : '0;
      frame_start <= at_origin_c;
      if (at_origin_c) begin
        mode_q       <= mode;
        solid_q      <= solid_rgb;
        seen_first_q <= 1'b1;
        // The first frame after reset is not a completed frame.
        if (seen_first_q) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Testbench for lcd_pattern_gen on a reduced raster (22 x 10 clocks per frame)
// so that a 257-frame run stays short. A reference model pushes the expected
// output of every clock edge onto a queue; tasks pop and compare it.
module tb_lcd_pattern_gen;

  localparam int unsigned H_A   = 16;
  localparam int unsigned H_FP  = 2;
  localparam int unsigned H_S   = 2;
  localparam int unsigned H_BP  = 2;
  localparam int unsigned V_A   = 6;
  localparam int unsigned V_FP  = 1;
  localparam int unsigned V_S   = 2;
  localparam int unsigned V_BP  = 1;
  localparam int unsigned H_T   = H_A + H_FP + H_S + H_BP;
  localparam int unsigned V_T   = V_A + V_FP + V_S + V_BP;
  localparam int unsigned FRAME = H_T * V_T;
  localparam int unsigned CB    = 1;
  localparam int unsigned CHK   = 2;
  localparam bit          HSP   = 1'b0;
  localparam bit          VSP   = 1'b1;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic [11:0] ax;
    logic [11:0] ay;
    logic        fs;
    logic [7:0]  fc;
  } out_t;

  typedef struct packed {
    logic [2:0]  md;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] rgb;
  } spot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mode;
  logic [15:0] solid_rgb;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic [11:0] active_x, active_y;
  logic [7:0]  frame_cnt;

  out_t got;
  assign got = {lcd_hs, lcd_vs, lcd_de, lcd_r, lcd_g, lcd_b,
                active_x, active_y, frame_start, frame_cnt};

  out_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int unsigned m_h, m_v, m_fc;
  logic [2:0]  m_mode;
  logic [15:0] m_solid;
  bit          m_seen;

  // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                              3'b101, 3'b100, 3'b001, 3'b000};

  spot_t spots [14] = '{
    '{3'd0, 12'd2,  12'd2, 16'b01000_010000_00000},
    '{3'd0, 12'd1,  12'd1, 16'h0000},
    '{3'd0, 12'd6,  12'd6, 16'b11000_110000_00000},
    '{3'd1, 12'd1,  12'd0, 16'hFFFF},
    '{3'd1, 12'd2,  12'd0, 16'hFFE0},
    '{3'd1, 12'd4,  12'd1, 16'h07FF},
    '{3'd1, 12'd15, 12'd0, 16'h0000},
    '{3'd2, 12'd13, 12'd2, 16'b00001_000011_00001},
    '{3'd3, 12'd4,  12'd0, 16'hFFFF},
    '{3'd3, 12'd4,  12'd4, 16'h0000},
    '{3'd3, 12'd0,  12'd4, 16'hFFFF},
    '{3'd4, 12'd5,  12'd3, 16'h07E0},
    '{3'd5, 12'd3,  12'd3, 16'h0000},
    '{3'd7, 12'd3,  12'd3, 16'h0000}
  };

  always #5 clk = ~clk;

  lcd_pattern_gen #(
    .H_ACTIVE(H_A), .H_FP(H_FP), .H_SYNC(H_S), .H_BP(H_BP),
    .V_ACTIVE(V_A), .V_FP(V_FP), .V_SYNC(V_S), .V_BP(V_BP),
    .HS_POL(HSP), .VS_POL(VSP),
    .R_W(5), .G_W(6), .B_W(5),
    .CB_SHIFT(CB), .CHK_SHIFT(CHK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .active_x(active_x), .active_y(active_y),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Reference model: predicts the output registered on this edge.
  always @(posedge clk) begin : model
    out_t       e;
    logic [2:0] bar;
    e    = '0;
    e.hs = ~HSP;
    e.vs = ~VSP;
    if (rst_n !== 1'b1) begin
      m_h = 0; m_v = 0; m_fc = 0; m_mode = '0; m_solid = '0; m_seen = 1'b0;
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_mode  = mode;
        m_solid = solid_rgb;
        e.fs    = 1'b1;
        if (m_seen) m_fc = (m_fc + 1) % 256;
        m_seen  = 1'b1;
      end
      e.fc = 8'(m_fc);
      if (m_h >= H_A + H_FP && m_h < H_A + H_FP + H_S) e.hs = HSP;
      if (m_v >= V_A + V_FP && m_v < V_A + V_FP + V_S) e.vs = VSP;
      if (m_h < H_A && m_v < V_A) begin
        e.de = 1'b1;
        e.ax = 12'(m_h);
        e.ay = 12'(m_v);
        case (m_mode)
          3'd0: begin
            e.r = 5'(((m_h >> CB) & 3) << 3);
            e.g = 6'(((m_v >> CB) & 3) << 4);
          end
          3'd1: begin
            bar = bar_tab[m_h / (H_A / 8)];
            e.r = bar[2] ? 5'h1F : 5'h00;
            e.g = bar[1] ? 6'h3F : 6'h00;
            e.b = bar[0] ? 5'h1F : 5'h00;
          end
          3'd2: begin
            e.r = 5'((m_h % 256) / 8);
            e.g = 6'((m_h % 256) / 4);
            e.b = 5'((m_h % 256) / 8);
          end
          3'd3: begin
            if ((((m_h >> CHK) ^ (m_v >> CHK)) & 1) == 1) begin
              e.r = 5'h1F; e.g = 6'h3F; e.b = 5'h1F;
            end
          end
          3'd4: {e.r, e.g, e.b} = m_solid;
          default: ;
        endcase
      end
      m_h = m_h + 1;
      if (m_h == H_T) begin
        m_h = 0;
        m_v = m_v + 1;
        if (m_v == V_T) m_v = 0;
      end
    end
    sb_q.push_back(e);
  end

  // Advance to the next sampling point (negedge) and pop its expectation.
  task automatic next_out(output out_t e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_underflow: got empty queue, required one entry");
      $fatal(1, "scoreboard underflow");
    end
    e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    out_t e;
    rst_n = 1'b0; mode = 3'd0; solid_rgb = '0;
    for (int i = 0; i < 4; i++) begin
      next_out(e);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_sb cyc %0d: got %h required %h", i, got, e);
      end
    end
    checks++;
    if (lcd_de !== 1'b0 || lcd_hs !== ~HSP || lcd_vs !== ~VSP || frame_start !== 1'b0 ||
        frame_cnt !== 8'd0 || {lcd_r, lcd_g, lcd_b} !== 16'h0 ||
        active_x !== 12'd0 || active_y !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: got de=%b hs=%b vs=%b fs=%b fc=%0d rgb=%h x=%0d y=%0d required 0,1,0,0,0,0,0,0",
               lcd_de, lcd_hs, lcd_vs, frame_start, frame_cnt, {lcd_r, lcd_g, lcd_b}, active_x, active_y);
    end
  endtask

  task automatic test_timing();
    out_t e;
    int run, run_bad, de_tot, hs_tot, vs_tot, fs_tot, hs_first, vs_first, fs_second;
    run = 0; run_bad = 0; de_tot = 0; hs_tot = 0; vs_tot = 0; fs_tot = 0;
    hs_first = -1; vs_first = -1; fs_second = -1;
    mode = 3'd0;
    rst_n = 1'b1;
    for (int c = 0; c < 2 * int'(FRAME); c++) begin
      next_out(e);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL timing_sb cyc %0d: got %h required %h", c, got, e);
      end
      if (c == 0) begin
        checks++;
        if (lcd_de !== 1'b1 || frame_start !== 1'b1 || active_x !== 12'd0 || active_y !== 12'd0) begin
          errors++;
          $display("FAIL first_pixel: got de=%b fs=%b x=%0d y=%0d required 1,1,0,0",
                   lcd_de, frame_start, active_x, active_y);
        end
      end
      if (c < int'(FRAME)) begin
        if (lcd_de === 1'b1) begin
          de_tot++; run++;
        end else begin
          if (run != 0 && run != int'(H_A)) run_bad++;
          run = 0;
        end
        if (lcd_hs === HSP) begin hs_tot++; if (hs_first < 0) hs_first = c; end
        if (lcd_vs === VSP) begin vs_tot++; if (vs_first < 0) vs_first = c; end
        if (frame_start === 1'b1) fs_tot++;
      end else if (frame_start === 1'b1 && fs_second < 0) begin
        fs_second = c;
      end
    end
    checks++;
    if (run_bad != 0 || de_tot != int'(H_A * V_A)) begin
      errors++;
      $display("FAIL de_runs: got bad_runs=%0d de_total=%0d required 0 and %0d", run_bad, de_tot, H_A * V_A);
    end
    checks++;
    if (hs_tot != int'(H_S * V_T) || hs_first != int'(H_A + H_FP)) begin
      errors++;
      $display("FAIL hs_timing: got count=%0d first=%0d required %0d and %0d",
               hs_tot, hs_first, H_S * V_T, H_A + H_FP);
    end
    checks++;
    if (vs_tot != int'(V_S * H_T) || vs_first != int'((V_A + V_FP) * H_T)) begin
      errors++;
      $display("FAIL vs_timing: got count=%0d first=%0d required %0d and %0d",
               vs_tot, vs_first, V_S * H_T, (V_A + V_FP) * H_T);
    end
    checks++;
    if (fs_tot != 1 || fs_second != int'(FRAME)) begin
      errors++;
      $display("FAIL frame_period: got pulses=%0d second_at=%0d required 1 and %0d", fs_tot, fs_second, FRAME);
    end
  endtask

  task automatic test_patterns();
    out_t e;
    bit   found;
    solid_rgb = 16'h07E0;
    for (int md = 0; md < 8; md++) begin
      mode  = 3'(md);
      found = 1'b0;
      for (int c = 0; c < 2 * int'(FRAME) && !found; c++) begin
        next_out(e);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL pattern_sync_sb mode %0d: got %h required %h", md, got, e);
        end
        if (e.fs) found = 1'b1;
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL pattern_frame_wait mode %0d: got no frame_start required one within %0d cycles", md, 2 * FRAME);
      end
      for (int c = 1; c < int'(FRAME); c++) begin
        next_out(e);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL pattern_sb mode %0d: got %h required %h", md, got, e);
        end
        foreach (spots[s]) begin
          if (spots[s].md == 3'(md) && e.de && e.ax == spots[s].x && e.ay == spots[s].y) begin
            checks++;
            if ({lcd_r, lcd_g, lcd_b} !== spots[s].rgb) begin
              errors++;
              $display("FAIL pattern_spot mode %0d (%0d,%0d): got %h required %h",
                       md, spots[s].x, spots[s].y, {lcd_r, lcd_g, lcd_b}, spots[s].rgb);
            end
          end
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    out_t e;
    int   phase, bad, npix;
    mode = 3'd0; solid_rgb = 16'h0000;
    phase = 0; bad = 0; npix = 0;
    // phase 0: reach a crossbar frame; 1: until line 3; 2: rest of frame; 3: next frame
    for (int c = 0; c < 5 * int'(FRAME) && phase < 4; c++) begin
      next_out(e);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL switch_sb phase %0d: got %h required %h", phase, got, e);
      end
      case (phase)
        0: if (e.fs) phase = 1;
        1: if (e.ay == 12'd3 && e.ax == 12'd0 && e.de) begin
             mode = 3'd4; solid_rgb = 16'hF800; phase = 2;
           end
        2: begin
             if (e.fs) phase = 3;
             else if (e.de && e.ax == 12'd6 && e.ay == 12'd4) begin
               checks++;
               if ({lcd_r, lcd_g, lcd_b} !== 16'b11000_100000_00000) begin
                 errors++;
                 $display("FAIL switch_same_frame (6,4): got %h required %h",
                          {lcd_r, lcd_g, lcd_b}, 16'b11000_100000_00000);
               end
             end
           end
        default: ;
      endcase
      if (phase == 3) begin
        if (lcd_de === 1'b1) begin
          npix++;
          if ({lcd_r, lcd_g, lcd_b} !== 16'hF800) bad++;
        end
        if (npix == int'(H_A * V_A)) phase = 4;
      end
    end
    checks++;
    if (phase != 4 || bad != 0) begin
      errors++;
      $display("FAIL switch_next_frame: got phase=%0d bad_pixels=%0d of %0d required phase 4 and 0 bad",
               phase, bad, npix);
    end
  endtask

  task automatic test_frame_wrap();
    out_t e;
    bit   wrapped;
    int   prev;
    wrapped = 1'b0; prev = -1;
    for (int c = 0; c < 257 * int'(FRAME); c++) begin
      next_out(e);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrap_sb cyc %0d: got %h required %h", c, got, e);
      end
      if (e.fs) begin
        if (prev == 255 && frame_cnt === 8'd0) wrapped = 1'b1;
        prev = int'(frame_cnt);
      end
    end
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL frame_cnt_wrap: got wrapped=%0d required 1", wrapped);
    end
  endtask

  task automatic test_reset_midline();
    out_t e;
    bit   found;
    found = 1'b0;
    for (int c = 0; c < 2 * int'(FRAME) && !found; c++) begin
      next_out(e);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL midrst_pre_sb: got %h required %h", got, e);
      end
      if (e.hs == HSP && e.ay == 12'd0) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL midrst_wait: got no hsync required one within %0d cycles", 2 * FRAME);
    end
    rst_n = 1'b0;
    mode  = 3'd1;
    next_out(e);
    checks++;
    if (got !== e || lcd_hs !== ~HSP || lcd_de !== 1'b0 || frame_cnt !== 8'd0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_values: got %h required %h", got, e);
    end
    rst_n = 1'b1;
    next_out(e);
    checks++;
    if (lcd_de !== 1'b1 || frame_start !== 1'b1 || active_x !== 12'd0 || active_y !== 12'd0 ||
        frame_cnt !== 8'd0 || {lcd_r, lcd_g, lcd_b} !== 16'hFFFF) begin
      errors++;
      $display("FAIL midrst_restart: got de=%b fs=%b x=%0d y=%0d fc=%0d rgb=%h required 1,1,0,0,0,ffff",
               lcd_de, frame_start, active_x, active_y, frame_cnt, {lcd_r, lcd_g, lcd_b});
    end
    for (int c = 1; c < int'(FRAME) + 2; c++) begin
      next_out(e);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL midrst_post_sb cyc %0d: got %h required %h", c, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_patterns();
    test_mode_switch();
    test_frame_wrap();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
